// File: rtl/leorv32_pkg.sv
// Shared leorv32 constants: Zicsr funct3 encodings, CSR addresses and op decode helpers.
package leorv32_pkg;

  localparam logic [2:0] FUNC_CSRRW  = 3'b001;
  localparam logic [2:0] FUNC_CSRRS  = 3'b010;
  localparam logic [2:0] FUNC_CSRRC  = 3'b011;
  localparam logic [2:0] FUNC_CSRRWI = 3'b101;
  localparam logic [2:0] FUNC_CSRRSI = 3'b110;
  localparam logic [2:0] FUNC_CSRRCI = 3'b111;

  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_TIME          = 12'hC01;
  localparam logic [11:0] CSR_TIMEH         = 12'hC81;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  typedef enum logic [1:0] {
    CSR_OP_WRITE,
    CSR_OP_SET,
    CSR_OP_CLEAR
  } csr_op_t;

  function automatic logic csr_func_valid(input logic [2:0] func);
    return func inside {FUNC_CSRRW, FUNC_CSRRS, FUNC_CSRRC,
                        FUNC_CSRRWI, FUNC_CSRRSI, FUNC_CSRRCI};
  endfunction

  // Register and immediate forms share funct3[1:0]
  function automatic csr_op_t csr_func_op(input logic [1:0] func_lo);
    case (func_lo)
      2'b10:   return CSR_OP_SET;
      2'b11:   return CSR_OP_CLEAR;
      default: return CSR_OP_WRITE;
    endcase
  endfunction

endpackage

// File: rtl/leorv32_csr_unit_if.sv
// CSR request/response bundle between the execute stage and the CSR unit.
interface leorv32_csr_unit_if;
  logic        req_valid;
  logic [11:0] req_addr;
  logic [2:0]  req_func;
  logic [31:0] req_wdata;
  logic        req_src_zero;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;

  modport master (
    output req_valid, req_addr, req_func, req_wdata, req_src_zero,
    input  rsp_valid, rsp_rdata, rsp_illegal
  );

  modport slave (
    input  req_valid, req_addr, req_func, req_wdata, req_src_zero,
    output rsp_valid, rsp_rdata, rsp_illegal
  );
endinterface

// File: rtl/leorv32_csr_counter.sv
// Wide counter with independently writable 32-bit lo half and upper half.
// A write in the same cycle as an increment wins; the increment is dropped.
module leorv32_csr_counter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (wr_lo) begin
      r_count[31:0] <= wdata;
    end else if (wr_hi) begin
      r_count[WIDTH-1:32] <= wdata[WIDTH-33:0];
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
endmodule

// File: rtl/leorv32_csr_unit.sv
// leorv32 Zicsr unit: counters, prescaled time, mhartid, mscratch, 1-cycle response.
// Optional mcountinhibit (0x320, CY/IR bits) when LEORV32_MCOUNTINHIBIT_EN is defined.
module leorv32_csr_unit
  import leorv32_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter logic [31:0] HART_ID       = 32'h0,
  parameter int unsigned TIME_PRESCALE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               retire,
  leorv32_csr_unit_if.slave  bus
);
  logic [COUNTER_WIDTH-1:0] w_cycle;
  logic [COUNTER_WIDTH-1:0] w_instret;
  logic [COUNTER_WIDTH-1:0] w_time;
  logic [15:0]              r_presc;
  logic                     w_tick;
  logic [31:0]              r_mscratch;
  logic                     w_inh_cy;
  logic                     w_inh_ir;
  logic                     w_mapped;
  logic                     w_func_ok;
  logic                     w_do_write;
  logic                     w_illegal;
  logic                     w_we;
  logic [31:0]              w_old;
  logic [31:0]              w_new;
  csr_op_t                  w_op;
  logic                     r_rsp_valid;
  logic                     r_rsp_illegal;
  logic [31:0]              r_rsp_rdata;

  assign w_op       = csr_func_op(bus.req_func[1:0]);
  assign w_func_ok  = csr_func_valid(bus.req_func);
  assign w_do_write = (w_op == CSR_OP_WRITE) || !bus.req_src_zero;
  assign w_illegal  = !w_mapped || !w_func_ok || (w_do_write && bus.req_addr[11:10] == 2'b11);
  assign w_we       = bus.req_valid && !w_illegal && w_do_write;

`ifdef LEORV32_MCOUNTINHIBIT_EN
  logic r_inh_cy;
  logic r_inh_ir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inh_cy <= 1'b0;
      r_inh_ir <= 1'b0;
    end else if (w_we && bus.req_addr == CSR_MCOUNTINHIBIT) begin
      r_inh_cy <= w_new[0];
      r_inh_ir <= w_new[2];
    end
  end

  assign w_inh_cy = r_inh_cy;
  assign w_inh_ir = r_inh_ir;
`else
  assign w_inh_cy = 1'b0;
  assign w_inh_ir = 1'b0;
`endif

  always_comb begin
    w_mapped = 1'b1;
    w_old    = '0;
    case (bus.req_addr)
      CSR_CYCLE,   CSR_MCYCLE:    w_old = w_cycle[31:0];
      CSR_CYCLEH,  CSR_MCYCLEH:   w_old = 32'(w_cycle[COUNTER_WIDTH-1:32]);
      CSR_INSTRET, CSR_MINSTRET:  w_old = w_instret[31:0];
      CSR_INSTRETH, CSR_MINSTRETH: w_old = 32'(w_instret[COUNTER_WIDTH-1:32]);
      CSR_TIME:                   w_old = w_time[31:0];
      CSR_TIMEH:                  w_old = 32'(w_time[COUNTER_WIDTH-1:32]);
      CSR_MHARTID:                w_old = HART_ID;
      CSR_MSCRATCH:               w_old = r_mscratch;
`ifdef LEORV32_MCOUNTINHIBIT_EN
      CSR_MCOUNTINHIBIT:          w_old = {29'b0, r_inh_ir, 1'b0, r_inh_cy};
`endif
      default:                    w_mapped = 1'b0;
    endcase
  end

  always_comb begin
    w_new = bus.req_wdata;
    case (w_op)
      CSR_OP_SET:   w_new = w_old | bus.req_wdata;
      CSR_OP_CLEAR: w_new = w_old & ~bus.req_wdata;
      default:      w_new = bus.req_wdata;
    endcase
  end

  leorv32_csr_counter #(.WIDTH(COUNTER_WIDTH)) u_cycle (
    .clk   (clk),
    .rst   (reset),
    .inc   (!w_inh_cy),
    .wr_lo (w_we && bus.req_addr == CSR_MCYCLE),
    .wr_hi (w_we && bus.req_addr == CSR_MCYCLEH),
    .wdata (w_new),
    .count (w_cycle)
  );

  leorv32_csr_counter #(.WIDTH(COUNTER_WIDTH)) u_instret (
    .clk   (clk),
    .rst   (reset),
    .inc   (retire && !w_inh_ir),
    .wr_lo (w_we && bus.req_addr == CSR_MINSTRET),
    .wr_hi (w_we && bus.req_addr == CSR_MINSTRETH),
    .wdata (w_new),
    .count (w_instret)
  );

  leorv32_csr_counter #(.WIDTH(COUNTER_WIDTH)) u_time (
    .clk   (clk),
    .rst   (reset),
    .inc   (w_tick),
    .wr_lo (1'b0),
    .wr_hi (1'b0),
    .wdata ('0),
    .count (w_time)
  );

  assign w_tick = (r_presc == 16'(TIME_PRESCALE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mscratch <= '0;
    end else if (w_we && bus.req_addr == CSR_MSCRATCH) begin
      r_mscratch <= w_new;
    end
  end

  // Read data is the pre-write value captured alongside the write edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_illegal <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_rsp_valid   <= bus.req_valid;
      r_rsp_illegal <= bus.req_valid && w_illegal;
      r_rsp_rdata   <= (bus.req_valid && !w_illegal) ? w_old : '0;
    end
  end

  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_illegal = r_rsp_illegal;
  assign bus.rsp_rdata   = r_rsp_rdata;
endmodule

// File: tb/tb_leorv32_csr_unit.sv
// Bench for leorv32_csr_unit: directed CSR traffic against a per-cycle reference model.
module tb_leorv32_csr_unit;
  import leorv32_pkg::*;

  localparam int unsigned CW   = 40;
  localparam logic [31:0] HID  = 32'h0000_0A5C;
  localparam int unsigned TP   = 4;
  localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic retire = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  leorv32_csr_unit_if bus();

  leorv32_csr_unit #(
    .COUNTER_WIDTH (CW),
    .HART_ID       (HID),
    .TIME_PRESCALE (TP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .retire (retire),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] m_cycle   = '0;
  logic [63:0] m_instret = '0;
  logic [63:0] m_time    = '0;
  int unsigned m_presc   = 0;
  logic [31:0] m_scratch = '0;
  logic        m_cy      = 1'b0;
  logic        m_ir      = 1'b0;
  logic        exp_valid   = 1'b0;
  logic        exp_illegal = 1'b0;
  logic [31:0] exp_rdata   = '0;

  function automatic logic model_read(input logic [11:0] a, output logic [31:0] v);
    v = '0;
    model_read = 1'b1;
    case (a)
      12'hC00, 12'hB00: v = m_cycle[31:0];
      12'hC80, 12'hB80: v = m_cycle[63:32];
      12'hC02, 12'hB02: v = m_instret[31:0];
      12'hC82, 12'hB82: v = m_instret[63:32];
      12'hC01:          v = m_time[31:0];
      12'hC81:          v = m_time[63:32];
      12'hF14:          v = HID;
      12'h340:          v = m_scratch;
`ifdef LEORV32_MCOUNTINHIBIT_EN
      12'h320:          v = {29'd0, m_ir, 1'b0, m_cy};
`endif
      default:          model_read = 1'b0;
    endcase
  endfunction

  // Reference model: one step per clock edge, using the inputs held since the previous negedge
  initial forever begin : model
    logic        ok_addr, ok_func, wr, ill;
    logic [31:0] old, nv, d;
    logic [63:0] nc, ni;
    @(posedge clk or posedge reset);
    if (reset) begin
      m_cycle = '0; m_instret = '0; m_time = '0; m_presc = 0;
      m_scratch = '0; m_cy = 1'b0; m_ir = 1'b0;
      exp_valid = 1'b0; exp_illegal = 1'b0; exp_rdata = '0;
    end else begin
      d       = bus.req_wdata;
      ok_addr = model_read(bus.req_addr, old);
      ok_func = bus.req_func inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
      wr      = (bus.req_func[1:0] == 2'b01) || !bus.req_src_zero;
      ill     = !ok_addr || !ok_func || (wr && bus.req_addr >= 12'hC00);
      exp_valid   = bus.req_valid;
      exp_illegal = bus.req_valid && ill;
      exp_rdata   = (bus.req_valid && !ill) ? old : 32'd0;
      case (bus.req_func[1:0])
        2'b10:   nv = old | d;
        2'b11:   nv = old & ~d;
        default: nv = d;
      endcase
      nc = m_cy ? m_cycle : ((m_cycle + 64'd1) & MASK);
      ni = (retire && !m_ir) ? ((m_instret + 64'd1) & MASK) : m_instret;
      if (m_presc == TP - 1) begin
        m_presc = 0;
        m_time  = (m_time + 64'd1) & MASK;
      end else begin
        m_presc = m_presc + 1;
      end
      if (bus.req_valid && !ill && wr) begin
        case (bus.req_addr)
          12'hB00: nc = (m_cycle & ~64'hFFFF_FFFF) | {32'd0, nv};
          12'hB80: nc = (({32'd0, nv} << 32) & MASK) | (m_cycle & 64'hFFFF_FFFF);
          12'hB02: ni = (m_instret & ~64'hFFFF_FFFF) | {32'd0, nv};
          12'hB82: ni = (({32'd0, nv} << 32) & MASK) | (m_instret & 64'hFFFF_FFFF);
          12'h340: m_scratch = nv;
          12'h320: begin m_cy = nv[0]; m_ir = nv[2]; end
          default: ;
        endcase
      end
      m_cycle   = nc;
      m_instret = ni;
    end
  end

  initial forever begin
    @(negedge clk);
    n_total++;
    if (bus.rsp_valid !== exp_valid) begin
      n_bad++;
      $display("FAIL rsp_valid t=%0t got=%b want=%b", $time, bus.rsp_valid, exp_valid);
    end else if (exp_valid) begin
      n_total++;
      if (bus.rsp_rdata !== exp_rdata) begin
        n_bad++;
        $display("FAIL rsp_rdata t=%0t got=%h want=%h", $time, bus.rsp_rdata, exp_rdata);
      end
      n_total++;
      if (bus.rsp_illegal !== exp_illegal) begin
        n_bad++;
        $display("FAIL rsp_illegal t=%0t got=%b want=%b", $time, bus.rsp_illegal, exp_illegal);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic req(input logic [11:0] a, input logic [2:0] f, input logic [31:0] d, input logic sz);
    bus.req_valid    = 1'b1;
    bus.req_addr     = a;
    bus.req_func     = f;
    bus.req_wdata    = d;
    bus.req_src_zero = sz;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    req(a, FUNC_CSRRS, 32'd0, 1'b1);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_func = '0;
    bus.req_wdata = '0; bus.req_src_zero = 1'b0;
    @(negedge clk);
    chk("reset_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_illegal", {31'd0, bus.rsp_illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    rd(CSR_CYCLE);                     chk("cycle_at_10", bus.rsp_rdata, 32'd10);
    chk("cycle_legal", {31'd0, bus.rsp_illegal}, 32'd0);
    req(CSR_MCYCLE, FUNC_CSRRW, 32'hFFFF_FFFF, 1'b0); chk("mcycle_old", bus.rsp_rdata, 32'd11);
    req(CSR_MCYCLEH, FUNC_CSRRW, 32'd0, 1'b0);        chk("mcycleh_old", bus.rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rd(CSR_CYCLEH);                    chk("carry_into_hi", bus.rsp_rdata, 32'd1);
    rd(CSR_CYCLE);                     chk("lo_after_carry", bus.rsp_rdata, 32'd2);

    req(CSR_MCYCLEH, FUNC_CSRRW, 32'hFFFF_FFFF, 1'b0);
    req(CSR_MCYCLE, FUNC_CSRRW, 32'hFFFF_FFFE, 1'b0);
    rd(CSR_CYCLEH);                    chk("hi_truncated", bus.rsp_rdata, 32'h0000_00FF);
    rd(CSR_CYCLE);                     chk("lo_at_max", bus.rsp_rdata, 32'hFFFF_FFFF);
    rd(CSR_CYCLEH);                    chk("hi_wrapped", bus.rsp_rdata, 32'd0);
    rd(CSR_CYCLE);                     chk("lo_wrapped", bus.rsp_rdata, 32'd1);

    req(CSR_INSTRET, FUNC_CSRRW, 32'd5, 1'b0);
    chk("ro_write_illegal", {31'd0, bus.rsp_illegal}, 32'd1);
    chk("ro_write_rdata", bus.rsp_rdata, 32'd0);
    rd(CSR_INSTRET);
    chk("ro_read_legal", {31'd0, bus.rsp_illegal}, 32'd0);
    chk("instret_unchanged", bus.rsp_rdata, 32'd0);
    req(CSR_CYCLE, FUNC_CSRRS, 32'd1, 1'b0); chk("ro_set_illegal", {31'd0, bus.rsp_illegal}, 32'd1);
    rd(12'h123);                       chk("unmapped_illegal", {31'd0, bus.rsp_illegal}, 32'd1);
    req(CSR_CYCLE, 3'b000, 32'd0, 1'b1); chk("func000_illegal", {31'd0, bus.rsp_illegal}, 32'd1);
    req(CSR_CYCLE, 3'b100, 32'd0, 1'b1); chk("func100_illegal", {31'd0, bus.rsp_illegal}, 32'd1);
    rd(CSR_MHARTID);                   chk("mhartid", bus.rsp_rdata, 32'h0000_0A5C);
    req(CSR_MHARTID, FUNC_CSRRW, 32'd0, 1'b0); chk("mhartid_write", {31'd0, bus.rsp_illegal}, 32'd1);
    req(CSR_MHARTID, FUNC_CSRRCI, 32'd0, 1'b1); chk("mhartid_rci0", bus.rsp_rdata, 32'h0000_0A5C);

    retire = 1'b1;
    req(CSR_MINSTRET, FUNC_CSRRW, 32'd100, 1'b0); chk("minstret_old", bus.rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    retire = 1'b0;
    rd(CSR_MINSTRET);                  chk("minstret_write_wins", bus.rsp_rdata, 32'd103);

    req(CSR_MSCRATCH, FUNC_CSRRWI, 32'h1F, 1'b0);   chk("mscratch_rwi", bus.rsp_rdata, 32'd0);
    req(CSR_MSCRATCH, FUNC_CSRRC, 32'h3, 1'b0);     chk("mscratch_rc", bus.rsp_rdata, 32'h1F);
    req(CSR_MSCRATCH, FUNC_CSRRS, 32'hFFFF, 1'b1);  chk("mscratch_rs_z", bus.rsp_rdata, 32'h1C);
    rd(CSR_MSCRATCH);                  chk("mscratch_final", bus.rsp_rdata, 32'h1C);

`ifdef LEORV32_MCOUNTINHIBIT_EN
    req(CSR_MCOUNTINHIBIT, FUNC_CSRRW, 32'hFFFF_FFFF, 1'b0); chk("minh_old", bus.rsp_rdata, 32'd0);
    retire = 1'b1;
    rd(CSR_MCOUNTINHIBIT);             chk("minh_bits", bus.rsp_rdata, 32'd5);
    rd(CSR_CYCLE);
    rd(CSR_INSTRET);                   chk("instret_frozen", bus.rsp_rdata, 32'd103);
    retire = 1'b0;
    req(CSR_MCOUNTINHIBIT, FUNC_CSRRWI, 32'd0, 1'b0);
    rd(CSR_CYCLE);
`else
    req(CSR_MCOUNTINHIBIT, FUNC_CSRRW, 32'd1, 1'b0);
    chk("minh_unmapped", {31'd0, bus.rsp_illegal}, 32'd1);
`endif

    bus.req_valid = 1'b1; bus.req_addr = CSR_CYCLE; bus.req_func = FUNC_CSRRS;
    bus.req_wdata = '0; bus.req_src_zero = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset_drop", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    rd(CSR_TIME);                      chk("time_prescaled", bus.rsp_rdata, 32'd10);
    rd(CSR_TIMEH);                     chk("timeh_zero", bus.rsp_rdata, 32'd0);
    rd(CSR_MSCRATCH);                  chk("mscratch_reset", bus.rsp_rdata, 32'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/leorv32_csr_unit.md
Name: leorv32_csr_unit

Overview:
Parametrised CSR/counter unit for the leorv32 core; successor to the fixed read-only cycle/time/instret/mhartid set.
- Executes all six Zicsr ops (CSRRW/S/C and immediate forms), one request per cycle, fixed 1-cycle response.
- Provides counters of configurable width, writable machine counters, a prescaled time base, mscratch, and illegal-access reporting.
- Sits beside the core's execute stage.

Parameters:
COUNTER_WIDTH, 64, width of cycle/time/instret counters (legal range 33..64); upper bits beyond the width read 0.
HART_ID, 0, 32-bit value returned by mhartid (0xF14).
TIME_PRESCALE, 1, clk cycles per time increment; legal range 1..65535.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  CSR request strobe; sampled every cycle
req_addr  in  12  CSR address
req_func  in  3  funct3; must be one of the six Zicsr encodings, anything else is illegal
req_wdata  in  32  rs1 value, or zero-extended uimm for immediate forms
req_src_zero  in  1  rs1 index / uimm is zero (suppresses write for S/C forms)
retire  in  1  one instruction retired this cycle
rsp_valid  out  1  response strobe, exactly one cycle after req_valid
rsp_rdata  out  32  old CSR value; 0 when illegal
rsp_illegal  out  1  illegal access; qualified by rsp_valid

Behaviour:
- Reset: rsp_valid=0, rsp_rdata=0, rsp_illegal=0; all counters, prescaler and mscratch = 0.
- Reset is asynchronous and may assert mid-request; the pending response is dropped.
- Latency and throughput:
  - req_valid at cycle N gives rsp_valid at N+1, with read data captured before any write takes effect.
  - Back-to-back requests are allowed every cycle.
  - The write updates state at the clock edge ending cycle N, so a request at N+1 observes it.
- Address map:
  - C00/C80 cycle lo/hi, read-only.
  - C01/C81 time lo/hi, read-only.
  - C02/C82 instret lo/hi, read-only.
  - B00/B80 mcycle lo/hi, read/write, aliases cycle.
  - B02/B82 minstret lo/hi, read/write, aliases instret.
  - F14 mhartid, read-only.
  - 340 mscratch, read/write.
- Hi halves return counter bits [COUNTER_WIDTH-1:32], zero-padded.
- Write rules:
  - CSRRW/CSRRWI always write.
  - S/C forms write only when req_src_zero=0: S computes old|wdata, C computes old&~wdata.
  - A write to a hi half updates only bits [COUNTER_WIDTH-1:32] and truncates the excess; same for lo/[31:0].
- Illegal access sets rsp_illegal=1 and rsp_rdata=0, and changes no state. Causes:
  - unmapped address;
  - invalid req_func;
  - a write to a read-only address (addr[11:10]==2'b11).
- cycle: +1 every clk. instret: +1 when retire=1. Both wrap from 2^COUNTER_WIDTH-1 to 0.
- Write vs increment in the same cycle: the written value wins and the increment is lost; counting resumes the next cycle.
  - A lo write still leaves the hi half as it was before the write, with no carry applied.
- time:
  - The prescaler counts 0..TIME_PRESCALE-1; time increments on terminal count, then the prescaler returns to 0.
  - TIME_PRESCALE=1 means time increments every cycle.
  - time is not writable.

Optional Feature:
Macro LEORV32_MCOUNTINHIBIT_EN.
- Defined:
  - Adds mcountinhibit at 0x320, read/write, reset 0; only bits 0 (CY) and 2 (IR) are implemented, all others read 0.
  - CY=1 freezes cycle; IR=1 freezes instret; time is unaffected.
  - A write that sets CY takes effect from the next cycle.
- Undefined: 0x320 is unmapped, so any access is illegal.

Decomposition:
- Package leorv32_pkg gains:
  - CSR_MCYCLE=12'hB00, CSR_MCYCLEH=12'hB80, CSR_MINSTRET=12'hB02, CSR_MINSTRETH=12'hB82, CSR_MSCRATCH=12'h340, CSR_MCOUNTINHIBIT=12'h320;
  - typedef enum csr_op_t {CSR_OP_WRITE, CSR_OP_SET, CSR_OP_CLEAR}.
- Existing FUNC_CSRR* and read-only CSR constants are reused.
- One sub-module, leorv32_csr_counter (params WIDTH; ports inc, wr_lo, wr_hi, wdata, count).
  - Instantiated for cycle, instret and time.
  - Write-over-increment priority lives inside it.

Test Plan:
- Reset released, idle 10 cycles, CSRRS C00 src_zero=1 -> rsp_rdata == cycle count at request (10 ± pipeline offset, checked against model), illegal=0.
- CSRRW B00 wdata=FFFFFFFF, then CSRRW B80 wdata=0, wait 2 cycles -> C80 reads 1, C00 reads small value (wrap into hi).
- CSRRW C02 wdata=5 -> rsp_illegal=1, rsp_rdata=0, instret unchanged; CSRRS C02 src_zero=1 -> legal.
- TIME_PRESCALE=4, 40 idle cycles -> time lo reads 10.
- CSRRW B02 wdata=100 with retire=1 in the same cycle -> next read of B02 = 100 plus only subsequent retires.
- CSRRWI 340 uimm=0x1F then CSRRC 340 wdata=0x3 -> second rsp_rdata=0x1F, third read 0x1C. With LEORV32_MCOUNTINHIBIT_EN: set 0x320=1 -> cycle frozen.
